ad5640_dac_sched: RTL and testbench

- Sequences updates to the AD5640 tuning DAC; shares it between two requesters: the host register interface and the GPSDO discipline loop.
- Arbitrates requests and slew-limits each change into steps of at most MAX_STEP codes.
- Holds every step stable long enough for the downstream change-triggered SPI writer to finish one 16-bit frame.
- Sits between the control/register logic and the ad5640_spi block; drives that block's 14-bit data input.

---
 rtl/ad5640_dac_sched_pkg.sv | 16 +
 rtl/dac_slew_step.sv | 41 ++++
 rtl/ad5640_dac_sched.sv | 117 +++++++++++
 tb/tb_ad5640_dac_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad5640_dac_sched_pkg.sv
// Shared types and constants for the AD5640 tuning-DAC scheduler.
// Also used by the slew-step helper.
package ad5640_sched_pkg;

  localparam int DAC_W = 14;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    STEP = 3'b010,
    HOLD = 3'b100
  } state_t;

  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_LOOP = 1'b1;

endpackage

// File: rtl/dac_slew_step.sv
// One slew-limited move of a DAC code toward its target.
// The move is at most MAX_STEP codes; at_target flags that no move is needed.
module dac_slew_step
  import ad5640_sched_pkg::*;
#(
  parameter int MAX_STEP = 256
) (
  input  logic [DAC_W-1:0] current,
  input  logic [DAC_W-1:0] target,
  output logic [DAC_W-1:0] next_code,
  output logic             at_target
);

  localparam logic [DAC_W:0] MAX_STEP_C = (DAC_W+1)'(MAX_STEP);

  logic signed [DAC_W:0] diff_s;
  logic [DAC_W:0]        mag_s;
  logic [DAC_W-1:0]      step_s;

  // Signed distance to target, clamped magnitude, and move in its direction
  always_comb begin
    diff_s = $signed({1'b0, target}) - $signed({1'b0, current});
    if (diff_s[DAC_W]) begin
      mag_s = (DAC_W+1)'(-diff_s);
    end else begin
      mag_s = (DAC_W+1)'(diff_s);
    end
    if (mag_s > MAX_STEP_C) begin
      step_s = MAX_STEP_C[DAC_W-1:0];
    end else begin
      step_s = mag_s[DAC_W-1:0];
    end
    if (diff_s[DAC_W]) begin
      next_code = current - step_s;
    end else begin
      next_code = current + step_s;
    end
    at_target = (diff_s == (DAC_W+1)'(0));
  end

endmodule

// File: rtl/ad5640_dac_sched.sv
// Arbitrates host and discipline-loop requests for the AD5640 tuning DAC.
// Each change is slew-limited and every step is held long enough for one SPI frame.
module ad5640_dac_sched
  import ad5640_sched_pkg::*;
#(
  parameter int               HOLD_CYCLES = 384,
  parameter int               MAX_STEP    = 256,
  parameter logic [DAC_W-1:0] RESET_CODE  = 14'h2000,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             host_valid,
  input  logic [DAC_W-1:0] host_data,
  output logic             host_ready,
  input  logic             loop_valid,
  input  logic [DAC_W-1:0] loop_data,
  output logic             loop_ready,
  output logic [DAC_W-1:0] dac_data,
  output logic             busy,
  output logic             last_src,
  output logic [CNT_W-1:0] update_cnt
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t           state_r;
  logic [DAC_W-1:0] dac_data_r;
  logic [DAC_W-1:0] target_r;
  logic [15:0]      hold_cnt_r;
  logic             busy_r;
  logic             last_src_r;
  logic [CNT_W-1:0] update_cnt_r;
  logic [DAC_W-1:0] next_code_s;
  logic             at_target_s;
  logic             host_accept_s;
  logic             loop_accept_s;

  // Host wins outright; the loop only sees ready when the host is not asking.
  assign host_ready    = ~rst & enable & (state_r == IDLE);
  assign loop_ready    = host_ready & ~host_valid;
  assign host_accept_s = host_valid & host_ready;
  assign loop_accept_s = loop_valid & loop_ready;

  assign dac_data   = dac_data_r;
  assign busy       = busy_r;
  assign last_src   = last_src_r;
  assign update_cnt = update_cnt_r;

  dac_slew_step #(
    .MAX_STEP (MAX_STEP)
  ) u_step (
    .current   (dac_data_r),
    .target    (target_r),
    .next_code (next_code_s),
    .at_target (at_target_s)
  );

  // Request acceptance, step/hold sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      dac_data_r   <= RESET_CODE;
      target_r     <= RESET_CODE;
      hold_cnt_r   <= 16'd0;
      busy_r       <= 1'b0;
      last_src_r   <= SRC_HOST;
      update_cnt_r <= CNT_W'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (host_accept_s) begin
            target_r   <= host_data;
            last_src_r <= SRC_HOST;
            state_r    <= STEP;
            busy_r     <= 1'b1;
          end else if (loop_accept_s) begin
            target_r   <= loop_data;
            last_src_r <= SRC_LOOP;
            state_r    <= STEP;
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        STEP: begin
          if (at_target_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            dac_data_r   <= next_code_s;
            update_cnt_r <= update_cnt_r + CNT_W'(1);
            hold_cnt_r   <= HOLD_LOAD;
            state_r      <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_r != 16'd0) begin
            hold_cnt_r <= hold_cnt_r - 16'd1;
          end else if ((dac_data_r == target_r) || !enable) begin
            // Dropping enable abandons the ramp at the last step taken
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= STEP;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad5640_dac_sched.sv
// Directed self-checking bench for ad5640_dac_sched with default parameters
// (HOLD_CYCLES=384, MAX_STEP=256, RESET_CODE=0x2000).
module tb_ad5640_dac_sched;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        host_valid;
  logic [13:0] host_data;
  logic        host_ready;
  logic        loop_valid;
  logic [13:0] loop_data;
  logic        loop_ready;
  logic [13:0] dac_data;
  logic        busy;
  logic        last_src;
  logic [15:0] update_cnt;

  int checks;
  int errors;

  ad5640_dac_sched dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .loop_valid (loop_valid),
    .loop_data  (loop_data),
    .loop_ready (loop_ready),
    .dac_data   (dac_data),
    .busy       (busy),
    .last_src   (last_src),
    .update_cnt (update_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL rst_host_ready got %b exp 0", host_ready); end
    checks++; if (loop_ready !== 1'b0) begin errors++; $display("FAIL rst_loop_ready got %b exp 0", loop_ready); end
    checks++; if (dac_data !== 14'h2000) begin errors++; $display("FAIL rst_dac got %h exp 2000", dac_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (last_src !== 1'b0) begin errors++; $display("FAIL rst_last_src got %b exp 0", last_src); end
    checks++; if (update_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", update_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL idle_host_ready got %b exp 1", host_ready); end
    checks++; if (loop_ready !== 1'b1) begin errors++; $display("FAIL idle_loop_ready got %b exp 1", loop_ready); end
  endtask

  task automatic test_single_step();
    host_data  = 14'h2100;
    host_valid = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", host_ready); end
    tick(1);
    host_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_acc got %b exp 1", busy); end
    checks++; if (dac_data !== 14'h2000) begin errors++; $display("FAIL single_dac_lat got %h exp 2000", dac_data); end
    tick(1);
    checks++; if (dac_data !== 14'h2100) begin errors++; $display("FAIL single_dac got %h exp 2100", dac_data); end
    checks++; if (update_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", update_cnt); end
    tick(383);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b exp 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %b exp 0", busy); end
  endtask

  task automatic test_ramp_down();
    logic [13:0] exp_dac;
    do_reset();
    host_data  = 14'h0000;
    host_valid = 1'b1;
    tick(1);
    host_valid = 1'b0;
    tick(1);
    exp_dac = 14'h1F00;
    checks++; if (dac_data !== exp_dac) begin errors++; $display("FAIL ramp_step1 got %h exp %h", dac_data, exp_dac); end
    for (int k = 2; k <= 32; k++) begin
      tick(384);
      checks++; if (dac_data !== exp_dac) begin errors++; $display("FAIL ramp_hold%0d got %h exp %h", k, dac_data, exp_dac); end
      exp_dac = exp_dac - 14'h0100;
      tick(1);
      checks++; if (dac_data !== exp_dac) begin errors++; $display("FAIL ramp_step%0d got %h exp %h", k, dac_data, exp_dac); end
    end
    checks++; if (dac_data !== 14'h0000) begin errors++; $display("FAIL ramp_final got %h exp 0000", dac_data); end
    checks++; if (update_cnt !== 16'd32) begin errors++; $display("FAIL ramp_cnt got %0d exp 32", update_cnt); end
    tick(383);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_tail got %b exp 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_drop got %b exp 0", busy); end
  endtask

  task automatic test_no_change();
    loop_data  = 14'h0000;
    loop_valid = 1'b1;
    #1;
    checks++; if (loop_ready !== 1'b1) begin errors++; $display("FAIL nochg_ready got %b exp 1", loop_ready); end
    tick(1);
    loop_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nochg_busy got %b exp 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nochg_busy_drop got %b exp 0", busy); end
    checks++; if (dac_data !== 14'h0000) begin errors++; $display("FAIL nochg_dac got %h exp 0000", dac_data); end
    checks++; if (update_cnt !== 16'd32) begin errors++; $display("FAIL nochg_cnt got %0d exp 32", update_cnt); end
    checks++; if (last_src !== 1'b1) begin errors++; $display("FAIL nochg_src got %b exp 1", last_src); end
  endtask

  task automatic test_back_to_back();
    host_data  = 14'h0100;
    loop_data  = 14'h0200;
    host_valid = 1'b1;
    loop_valid = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL prio_host_ready got %b exp 1", host_ready); end
    checks++; if (loop_ready !== 1'b0) begin errors++; $display("FAIL prio_loop_ready got %b exp 0", loop_ready); end
    tick(1);
    host_valid = 1'b0;
    checks++; if (last_src !== 1'b0) begin errors++; $display("FAIL prio_src_host got %b exp 0", last_src); end
    tick(1);
    checks++; if (dac_data !== 14'h0100) begin errors++; $display("FAIL prio_host_dac got %h exp 0100", dac_data); end
    checks++; if (loop_ready !== 1'b0) begin errors++; $display("FAIL prio_busy_loop_ready got %b exp 0", loop_ready); end
    tick(384);
    checks++; if (loop_ready !== 1'b1) begin errors++; $display("FAIL prio_loop_ready_idle got %b exp 1", loop_ready); end
    tick(1);
    loop_valid = 1'b0;
    checks++; if (last_src !== 1'b1) begin errors++; $display("FAIL prio_src_loop got %b exp 1", last_src); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_loop_busy got %b exp 1", busy); end
    tick(1);
    checks++; if (dac_data !== 14'h0200) begin errors++; $display("FAIL prio_loop_dac got %h exp 0200", dac_data); end
    checks++; if (update_cnt !== 16'd34) begin errors++; $display("FAIL prio_cnt got %0d exp 34", update_cnt); end
    tick(384);
  endtask

  task automatic test_enable_drop();
    do_reset();
    host_data  = 14'h3000;
    host_valid = 1'b1;
    tick(1);
    host_valid = 1'b0;
    tick(1);
    tick(385 * 2);
    checks++; if (dac_data !== 14'h2300) begin errors++; $display("FAIL en_step3 got %h exp 2300", dac_data); end
    enable = 1'b0;
    tick(383);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_busy_hold got %b exp 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_abandon got %b exp 0", busy); end
    host_valid = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL en_no_ready got %b exp 0", host_ready); end
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_no_accept got %b exp 0", busy); end
    checks++; if (dac_data !== 14'h2300) begin errors++; $display("FAIL en_dac_held got %h exp 2300", dac_data); end
    checks++; if (update_cnt !== 16'd3) begin errors++; $display("FAIL en_cnt got %0d exp 3", update_cnt); end
    host_valid = 1'b0;
    enable     = 1'b1;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    host_data  = 14'h3000;
    host_valid = 1'b1;
    tick(1);
    host_valid = 1'b0;
    tick(1);
    tick(385 * 5);
    tick(10);
    checks++; if (dac_data !== 14'h2600) begin errors++; $display("FAIL rmid_dac got %h exp 2600", dac_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %b exp 1", busy); end
    rst        = 1'b1;
    loop_valid = 1'b1;
    #1;
    checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL rmid_host_ready got %b exp 0", host_ready); end
    checks++; if (loop_ready !== 1'b0) begin errors++; $display("FAIL rmid_loop_ready got %b exp 0", loop_ready); end
    tick(1);
    checks++; if (dac_data !== 14'h2000) begin errors++; $display("FAIL rmid_dac_rst got %h exp 2000", dac_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_rst got %b exp 0", busy); end
    checks++; if (update_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d exp 0", update_cnt); end
    rst        = 1'b0;
    loop_valid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    clk        = 1'b0;
    rst        = 1'b1;
    enable     = 1'b1;
    host_valid = 1'b0;
    host_data  = 14'h0000;
    loop_valid = 1'b0;
    loop_data  = 14'h0000;
    test_reset();
    test_single_step();
    test_ramp_down();
    test_no_change();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
